// File: rtl/pc_next_unit.sv
// Fetch program-counter stage: holds the fetch PC, advances it under the fetch handshake,
// applies execute-stage redirects and traps misaligned targets. Optional macro: PC_RVC_EN.
module pc_next_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_i,
    input  logic            redirect_jalr_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] imm_i,
`ifdef PC_RVC_EN
    input  logic            insn_half_i,
`endif
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fetch_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake: a fetch of pc_o happens in a cycle where fetch_valid_o && fetch_ready_i;
    // fetch_valid_o never drops in RUN until that cycle, except on a redirect or trap.

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_VEC);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] bad_addr_q;
    logic            fetch_valid_q;
    logic            misalign_q;

    logic [XLEN-1:0] step_d;
    logic [XLEN-1:0] base_d;
    logic [XLEN-1:0] sum_d;
    logic [XLEN-1:0] target_d;
    logic            target_bad_d;

    always_comb begin
`ifdef PC_RVC_EN
        step_d = insn_half_i ? XLEN'(2) : XLEN'(4);
`else
        step_d = XLEN'(4);
`endif
        base_d   = redirect_jalr_i ? rs1_i : ex_pc_i;
        sum_d    = base_d + imm_i;
        // JALR clears bit 0 of its target before alignment is judged.
        target_d = {sum_d[XLEN-1:1], sum_d[0] & ~redirect_jalr_i};
`ifdef PC_RVC_EN
        target_bad_d = target_d[0];
`else
        target_bad_d = |target_d[1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            bad_addr_q    <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (redirect_i) begin
                        if (target_bad_d) begin
                            state_q       <= ST_TRAP;
                            pc_q          <= TRAP_PC;
                            bad_addr_q    <= target_d;
                            misalign_q    <= 1'b1;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            pc_q <= target_d;
                        end
                    end else if (!stall_i && fetch_valid_q && fetch_ready_i) begin
                        pc_q <= pc_q + step_d;
                    end
                end
                ST_TRAP: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= ST_BOOT;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + step_d;
    assign fetch_valid_o = fetch_valid_q;
    assign misalign_o    = misalign_q;
    assign bad_addr_o    = bad_addr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: driver pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_next_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            ready;
    logic            redir;
    logic            jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm;
    logic            half;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_valid;
    logic            misalign;
    logic [XLEN-1:0] bad_addr;
    logic [1:0]      state;

    // {pc, fetch_valid, misalign, bad_addr, state}
    localparam int W = XLEN + 1 + 1 + XLEN + 2;
    logic [W-1:0] exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    pc_next_unit #(
        .XLEN(XLEN),
        .RESET_VEC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall),
        .fetch_ready_i(ready),
        .redirect_i(redir),
        .redirect_jalr_i(jalr),
        .ex_pc_i(ex_pc),
        .rs1_i(rs1),
        .imm_i(imm),
`ifdef PC_RVC_EN
        .insn_half_i(half),
`endif
        .pc_o(pc),
        .pc_plus4_o(pc_plus4),
        .fetch_valid_o(fetch_valid),
        .misalign_o(misalign),
        .bad_addr_o(bad_addr),
        .dbg_state_o(state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic s, input logic rdy, input logic rd,
                         input logic j, input logic [XLEN-1:0] ep, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] im);
        rst = r; stall = s; ready = rdy; redir = rd; jalr = j; ex_pc = ep; rs1 = r1; imm = im;
    endtask

    // Waits one edge, then records what the outputs must show for the cycle that follows.
    task automatic tick(input logic [XLEN-1:0] e_pc, input logic e_fv, input logic e_mis,
                        input logic [XLEN-1:0] e_bad, input logic [1:0] e_st);
        @(posedge clk);
        #1;
        exp_q.push_back({e_pc, e_fv, e_mis, e_bad, e_st});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0]    e;
            logic [XLEN-1:0] e_pc, e_bad, e_p4;
            logic            e_fv, e_mis;
            logic [1:0]      e_st;
            e = exp_q.pop_front();
            {e_pc, e_fv, e_mis, e_bad, e_st} = e;
`ifdef PC_RVC_EN
            e_p4 = e_pc + (half ? 32'd2 : 32'd4);
`else
            e_p4 = e_pc + 32'd4;
`endif
            n_total++;
            if (pc === e_pc && pc_plus4 === e_p4 && fetch_valid === e_fv &&
                misalign === e_mis && bad_addr === e_bad && state === e_st) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_check t=%0t got pc=%h p4=%h fv=%b mis=%b bad=%h st=%0d want pc=%h p4=%h fv=%b mis=%b bad=%h st=%0d",
                         $time, pc, pc_plus4, fetch_valid, misalign, bad_addr, state,
                         e_pc, e_p4, e_fv, e_mis, e_bad, e_st);
            end
        end
    end

    initial begin
        half = 1'b0;
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        // Two reset cycles, then the BOOT cycle with no valid fetch.
        tick(32'h0, 0, 0, 32'h0, S_BOOT);
        tick(32'h0, 0, 0, 32'h0, S_BOOT);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h0,  1, 0, 32'h0, S_RUN);
        tick(32'h4,  1, 0, 32'h0, S_RUN);
        tick(32'h8,  1, 0, 32'h0, S_RUN);
        tick(32'hC,  1, 0, 32'h0, S_RUN);
        tick(32'h10, 1, 0, 32'h0, S_RUN);
        // Back-pressure for three cycles, then stall for two.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(32'h10, 1, 0, 32'h0, S_RUN);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(32'h10, 1, 0, 32'h0, S_RUN);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h14, 1, 0, 32'h0, S_RUN);
        // Branch redirect wins over stall: 0x40 + (-16) = 0x30.
        drive(0, 1, 1, 1, 0, 32'h40, 0, 32'hFFFF_FFF0);
        tick(32'h30, 1, 0, 32'h0, S_RUN);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h34, 1, 0, 32'h0, S_RUN);
        // JALR to 0x101 clears bit 0; JALR to 0x102 traps.
        drive(0, 0, 1, 1, 1, 0, 32'h101, 0);
        tick(32'h100, 1, 0, 32'h0, S_RUN);
        drive(0, 0, 1, 1, 1, 0, 32'h102, 0);
        tick(32'h100, 0, 1, 32'h102, S_TRAP);
        // Redirect during TRAP is ignored.
        drive(0, 0, 1, 1, 0, 32'h200, 0, 0);
        tick(32'h100, 1, 0, 32'h102, S_RUN);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h104, 1, 0, 32'h102, S_RUN);
        // Wrap from the top of the address space.
        drive(0, 0, 1, 1, 0, 32'hFFFF_FFF8, 0, 32'h4);
        tick(32'hFFFF_FFFC, 1, 0, 32'h102, S_RUN);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h0, 1, 0, 32'h102, S_RUN);
        tick(32'h4, 1, 0, 32'h102, S_RUN);
`ifndef PC_RVC_EN
        // Branch target 0x22 is halfword-aligned only: traps without compressed support.
        drive(0, 0, 1, 1, 0, 32'h20, 0, 32'h2);
        tick(32'h100, 0, 1, 32'h22, S_TRAP);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h100, 1, 0, 32'h22, S_RUN);
`endif
        // Reset together with a misaligned redirect: reset wins.
        drive(1, 0, 1, 1, 0, 32'h20, 0, 32'h1);
        tick(32'h0, 0, 0, 32'h0, S_BOOT);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick(32'h0, 1, 0, 32'h0, S_RUN);
        tick(32'h4, 1, 0, 32'h0, S_RUN);
        tick(32'h8, 1, 0, 32'h0, S_RUN);
`ifdef PC_RVC_EN
        half = 1'b1;
        tick(32'hA, 1, 0, 32'h0, S_RUN);
        half = 1'b0;
        drive(0, 0, 1, 1, 0, 32'h10, 0, 32'hE);
        tick(32'h1E, 1, 0, 32'h0, S_RUN);
        drive(0, 0, 1, 1, 0, 32'h10, 0, 32'hF);
        tick(32'h100, 0, 1, 32'h1F, S_TRAP);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h100, 1, 0, 32'h1F, S_RUN);
`else
        tick(32'hC, 1, 0, 32'h0, S_RUN);
`endif
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Parametrised program-counter stage for the RV32I core. It is the successor to the PC+4 and PC+imm adders. It holds the architectural fetch PC in a register and advances it under a fetch handshake and a hazard stall. It also resolves branch and JALR redirects from execute, and traps misaligned targets to a fixed vector. It sits between the hazard unit / execute stage and the instruction memory port.

Parameters:
XLEN, 32, datapath and PC width in bits (>= 8)
RESET_VEC, 32'h0000_0000, PC value loaded on reset (truncated to XLEN)
TRAP_VEC, 32'h0000_0100, PC value loaded on a misaligned-target trap

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  hazard-unit hold; PC does not advance while high
fetch_ready_i  input  1  instruction memory accepts the current pc_o
redirect_i  input  1  execute stage requests a control-flow change this cycle
redirect_jalr_i  input  1  1: target base is rs1_i (JALR); 0: target base is ex_pc_i (branch/JAL)
ex_pc_i  input  XLEN  PC of the redirecting instruction
rs1_i  input  XLEN  rs1 operand for JALR
imm_i  input  XLEN  sign-extended immediate
pc_o  output  XLEN  registered fetch PC
pc_plus4_o  output  XLEN  pc_o + 4, combinational, wraps mod 2^XLEN
fetch_valid_o  output  1  pc_o is a valid fetch request
misalign_o  output  1  one-cycle pulse on misaligned redirect target
bad_addr_o  output  XLEN  offending target of the last trap

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous, active-high (rst) and overrides every other input.
- Values after reset: pc_o=RESET_VEC, fetch_valid_o=0, misalign_o=0, bad_addr_o=0, state=BOOT.
- FSM states: BOOT, RUN, TRAP.
  - BOOT: lasts exactly one cycle, then goes to RUN; fetch_valid_o=1 from the first RUN cycle. Redirects are ignored in BOOT.
  - RUN: fetch_valid_o=1.
  - TRAP: lasts exactly one cycle with fetch_valid_o=0, then returns to RUN. redirect_i is ignored in TRAP.
- Target computation: target = base + imm_i, modulo 2^XLEN.
  - base = rs1_i when redirect_jalr_i=1, otherwise ex_pc_i.
  - For JALR, target bit 0 is forced to 0 before the alignment check.
- Priority in RUN, evaluated each cycle: redirect_i > stall_i > advance.
  - Redirect with target[1:0]==0: pc_o <= target next cycle, regardless of fetch_ready_i or stall_i; state stays RUN.
  - Redirect with target[1:0]!=0: pc_o <= TRAP_VEC, bad_addr_o <= target, misalign_o=1 for one cycle, state <= TRAP.
  - Stall (stall_i=1, no redirect): pc_o holds.
  - Advance: when fetch_valid_o && fetch_ready_i && !stall_i, pc_o <= pc_o + 4.
  - Neither advance nor redirect: pc_o holds, and fetch_valid_o stays high until accepted.
- Wrap-around: pc_o = 2^XLEN-4 advances to 0 with no flag. pc_plus4_o wraps the same way.
- bad_addr_o holds its value until the next trap or reset.
- Latency: every PC update is visible on pc_o one cycle after the qualifying edge. There is no combinational path from redirect_i to pc_o.
- Adders: internal adders are XLEN-bit; carry-out is discarded.

Optional Feature:
PC_RVC_EN
- Defined: the unit supports 16-bit compressed instructions.
  - Adds input insn_half_i (1 bit): the accepted instruction is 16-bit.
  - Advance step is 2 when insn_half_i=1, otherwise 4.
  - pc_plus4_o = pc_o + (insn_half_i ? 2 : 4).
  - The alignment check tests target[0] only.
- Undefined: insn_half_i does not exist, the step is always 4, and the check tests target[1:0].

Test Plan:
- Reset, then handshake: assert rst for 2 cycles with RESET_VEC=0 -> pc_o=0 and fetch_valid_o=0 during reset and for the BOOT cycle. Hold fetch_ready_i=1 -> pc_o reads 0, 4, 8, 12 on successive cycles.
- Back-pressure and stall: drop fetch_ready_i for 3 cycles at pc_o=0x10 -> pc_o holds 0x10 with fetch_valid_o=1. Then assert stall_i for 2 cycles with ready=1 -> pc_o still 0x10, resumes at 0x14.
- Branch redirect: redirect_i=1, redirect_jalr_i=0, ex_pc_i=0x40, imm_i=0xFFFF_FFF0, during stall_i=1 -> next pc_o=0x30.
- JALR clear and trap: rs1_i=0x101, imm_i=0, jalr=1 -> pc_o=0x100, no trap. rs1_i=0x102, imm_i=0 -> pc_o=TRAP_VEC, misalign_o pulses 1 cycle, bad_addr_o=0x102, fetch_valid_o=0 for 1 cycle. A redirect asserted in the TRAP cycle is ignored.
- Wrap: force pc_o to 0xFFFF_FFFC via redirect, accept -> pc_o=0, pc_plus4_o=4.
- Reset mid-redirect (with PC_RVC_EN, second check): assert rst together with redirect_i -> pc_o=RESET_VEC, misalign_o=0. With PC_RVC_EN, insn_half_i=1 at pc_o=0x8 -> pc_o=0xA. A branch target of 0x1E is accepted; a target of 0x1F traps.
